// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file.
package regfile_pkg;

    localparam int REGFILE_DATA_WIDTH = 32;
    localparam int REGFILE_ADDR_WIDTH = 5;
    localparam int REGFILE_DEPTH      = 2 ** REGFILE_ADDR_WIDTH;

    typedef logic [REGFILE_DATA_WIDTH-1:0] word_t;
    typedef logic [REGFILE_ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/regfile_reg.sv
// One register-file entry: enable-loaded word with async active-high clear.
module regfile_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file, one write port, two combinational reads.
// Define REGFILE_BYPASS_EN for write-through of data_writeReg to matching read ports.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  ctrl_writeEn,
    input  logic                  ctrl_reset,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB
);

    localparam int NREG = 2 ** ADDR_WIDTH;

    logic [NREG-1:0]       write_sel;
    logic [DATA_WIDTH-1:0] regs [NREG];
    logic [DATA_WIDTH-1:0] read_a;
    logic [DATA_WIDTH-1:0] read_b;

    always_comb begin
        write_sel = '0;
        for (int i = 0; i < NREG; i++) begin
            write_sel[i] = ctrl_writeEn && (ctrl_writeReg == ADDR_WIDTH'(i));
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        regfile_reg #(
            .WIDTH (DATA_WIDTH)
        ) u_reg (
            .clock  (clock),
            .clear  (ctrl_reset),
            .enable (write_sel[g]),
            .d      (data_writeReg),
            .q      (regs[g])
        );
    end

    always_comb begin
        read_a = regs[ctrl_readRegA];
        read_b = regs[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
        if (ctrl_writeEn && (ctrl_readRegA == ctrl_writeReg)) begin
            read_a = data_writeReg;
        end
        if (ctrl_writeEn && (ctrl_readRegB == ctrl_writeReg)) begin
            read_b = data_writeReg;
        end
`else
        read_a = read_a;
        read_b = read_b;
`endif
    end

    // Force zero during reset so bypassed write data cannot leak out.
    assign data_readRegA = ctrl_reset ? '0 : read_a;
    assign data_readRegB = ctrl_reset ? '0 : read_b;

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile.
module tb_regfile;

    logic        clock;
    logic        ctrl_writeEn;
    logic        ctrl_reset;
    logic [4:0]  ctrl_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_writeReg;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;

    int checks;
    int failures;
    logic [31:0] model [32];

    regfile dut (
        .clock         (clock),
        .ctrl_writeEn  (ctrl_writeEn),
        .ctrl_reset    (ctrl_reset),
        .ctrl_writeReg (ctrl_writeReg),
        .ctrl_readRegA (ctrl_readRegA),
        .ctrl_readRegB (ctrl_readRegB),
        .data_writeReg (data_writeReg),
        .data_readRegA (data_readRegA),
        .data_readRegB (data_readRegB)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic write_reg(input int idx, input logic [31:0] val);
        @(negedge clock);
        ctrl_writeEn  = 1'b1;
        ctrl_writeReg = 5'(idx);
        data_writeReg = val;
        @(posedge clock);
        #1;
        ctrl_writeEn = 1'b0;
        model[idx] = val;
    endtask

    task automatic test_reset;
        @(negedge clock);
        ctrl_reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold a=%h b=%h want 0", data_readRegA, data_readRegB);
        end
        @(negedge clock);
        ctrl_reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            #1;
            checks++;
            if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
                failures++;
                $display("FAIL reset_read[%0d] a=%h b=%h want 0", i, data_readRegA, data_readRegB);
            end
        end
    endtask

    task automatic test_all_regs;
        for (int i = 0; i < 32; i++) begin
            write_reg(i, 32'h0000DEAD);
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(i);
            #1;
            checks++;
            if (data_readRegA !== 32'h0000DEAD || data_readRegB !== 32'h0000DEAD) begin
                failures++;
                $display("FAIL dead[%0d] a=%h b=%h want 0000dead", i, data_readRegA, data_readRegB);
            end
        end
        for (int i = 0; i < 32; i++) write_reg(i, 32'h5A000000 | (32'(i) << 8) | 32'(i));
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            #1;
            checks++;
            if (data_readRegA !== model[i] || data_readRegB !== model[31 - i]) begin
                failures++;
                $display("FAIL unique[%0d] a=%h want %h b=%h want %h", i,
                         data_readRegA, model[i], data_readRegB, model[31 - i]);
            end
        end
    endtask

    task automatic test_two_ports;
        write_reg(5, 32'h12345678);
        write_reg(6, 32'hCAFEF00D);
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd6;
        #1;
        checks++;
        if (data_readRegA !== 32'h12345678 || data_readRegB !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL ports a=%h want 12345678 b=%h want cafef00d", data_readRegA, data_readRegB);
        end
        ctrl_readRegA = 5'd6;
        ctrl_readRegB = 5'd5;
        #1;
        checks++;
        if (data_readRegA !== 32'hCAFEF00D || data_readRegB !== 32'h12345678) begin
            failures++;
            $display("FAIL ports_swap a=%h want cafef00d b=%h want 12345678", data_readRegA, data_readRegB);
        end
    endtask

    task automatic test_write_disable;
        write_reg(7, 32'h0BADBEEF);
        @(negedge clock);
        ctrl_writeEn  = 1'b0;
        ctrl_writeReg = 5'd7;
        data_writeReg = 32'hFFFFFFFF;
        ctrl_readRegA = 5'd7;
        ctrl_readRegB = 5'd8;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (data_readRegA !== 32'h0BADBEEF || data_readRegB !== model[8]) begin
            failures++;
            $display("FAIL wen_off a=%h want 0badbeef b=%h want %h", data_readRegA, data_readRegB, model[8]);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clock);
        ctrl_writeEn  = 1'b1;
        ctrl_writeReg = 5'd10;
        data_writeReg = 32'h10101010;
        @(negedge clock);
        ctrl_writeReg = 5'd11;
        data_writeReg = 32'h11111111;
        @(negedge clock);
        ctrl_writeReg = 5'd12;
        data_writeReg = 32'h12121212;
        @(negedge clock);
        ctrl_writeEn = 1'b0;
        model[10] = 32'h10101010;
        model[11] = 32'h11111111;
        model[12] = 32'h12121212;
        for (int i = 9; i <= 13; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(i);
            #1;
            checks++;
            if (data_readRegA !== model[i] || data_readRegB !== model[i]) begin
                failures++;
                $display("FAIL b2b[%0d] a=%h b=%h want %h", i, data_readRegA, data_readRegB, model[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        write_reg(9, 32'hAAAA5555);
        @(negedge clock);
        ctrl_readRegA = 5'd9;
        ctrl_readRegB = 5'd5;
        #1;
        checks++;
        if (data_readRegA !== 32'hAAAA5555) begin
            failures++;
            $display("FAIL pre_rst a=%h want aaaa5555", data_readRegA);
        end
        ctrl_writeEn  = 1'b1;
        ctrl_writeReg = 5'd9;
        data_writeReg = 32'h77777777;
        #1;
        ctrl_reset = 1'b1;
        #1;
        checks++;
        if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
            failures++;
            $display("FAIL async_rst a=%h b=%h want 0", data_readRegA, data_readRegB);
        end
        @(posedge clock);
        #1;
        checks++;
        if (data_readRegA !== 32'h0) begin
            failures++;
            $display("FAIL rst_blocks_write a=%h want 0", data_readRegA);
        end
        @(negedge clock);
        ctrl_writeEn = 1'b0;
        #1;
        ctrl_reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        checks++;
        if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
            failures++;
            $display("FAIL post_rst a=%h b=%h want 0", data_readRegA, data_readRegB);
        end
        write_reg(9, 32'h99999999);
        #1;
        checks++;
        if (data_readRegA !== 32'h99999999) begin
            failures++;
            $display("FAIL first_write a=%h want 99999999", data_readRegA);
        end
    endtask

    task automatic test_same_cycle;
        logic [31:0] expect_pre;
        write_reg(3, 32'h00003333);
        @(negedge clock);
        ctrl_writeEn  = 1'b1;
        ctrl_writeReg = 5'd3;
        data_writeReg = 32'hBEEF0003;
        ctrl_readRegA = 5'd3;
        ctrl_readRegB = 5'd4;
`ifdef REGFILE_BYPASS_EN
        expect_pre = 32'hBEEF0003;
`else
        expect_pre = 32'h00003333;
`endif
        #1;
        checks++;
        if (data_readRegA !== expect_pre || data_readRegB !== model[4]) begin
            failures++;
            $display("FAIL same_pre a=%h want %h b=%h want %h", data_readRegA, expect_pre,
                     data_readRegB, model[4]);
        end
        @(posedge clock);
        #1;
        ctrl_writeEn = 1'b0;
        model[3] = 32'hBEEF0003;
        #1;
        checks++;
        if (data_readRegA !== 32'hBEEF0003) begin
            failures++;
            $display("FAIL same_post a=%h want beef0003", data_readRegA);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        ctrl_reset    = 1'b1;
        ctrl_writeEn  = 1'b0;
        ctrl_writeReg = '0;
        ctrl_readRegA = '0;
        ctrl_readRegB = '0;
        data_writeReg = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        test_reset;
        test_all_regs;
        test_two_ports;
        test_write_disable;
        test_back_to_back;
        test_async_reset;
        test_same_cycle;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 32, register and data-port width in bits.
REQ-002 Parameters: ADDR_WIDTH, 5, register-index width; the file SHALL hold 2**ADDR_WIDTH registers (32 by default).
REQ-003 Ports SHALL appear in this positional order: clock, ctrl_writeEn, ctrl_reset, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, data_writeReg, data_readRegA, data_readRegB.
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 ctrl_reset  input  1  reset, asynchronous, active-high.
REQ-006 ctrl_writeEn  input  1  write enable, sampled on the rising edge of clock.
REQ-007 ctrl_writeReg  input  ADDR_WIDTH  index of the register to write.
REQ-008 ctrl_readRegA  input  ADDR_WIDTH  read port A index.
REQ-009 ctrl_readRegB  input  ADDR_WIDTH  read port B index.
REQ-010 data_writeReg  input  DATA_WIDTH  write data.
REQ-011 data_readRegA  output  DATA_WIDTH  contents of register ctrl_readRegA.
REQ-012 data_readRegB  output  DATA_WIDTH  contents of register ctrl_readRegB.

Function
REQ-013 On a rising clock edge with ctrl_writeEn=1 and ctrl_reset=0, the register selected by ctrl_writeReg SHALL load data_writeReg; no other register changes.
REQ-014 With ctrl_writeEn=0, no register SHALL change.
REQ-015 All registers, including index 0, SHALL be writable and SHALL retain written values (no hardwired-zero register).
REQ-016 Reads SHALL be combinational: data_readRegA/B reflect the addressed register's current contents in the same cycle, with no clock latency.
REQ-017 Both read ports SHALL be independent and may address the same or different registers, including the register being written.
REQ-018 Without bypass (see Configuration), a read of the register being written SHALL return the old value until the write edge, then the new value.
REQ-019 Outputs SHALL never be X/Z once reset has been applied, for any index.

Reset
REQ-020 ctrl_reset=1 SHALL clear every register to 0 immediately, independent of clock.
REQ-021 While ctrl_reset=1, writes SHALL be ignored and both read ports SHALL output 0.
REQ-022 Reset deassertion SHALL take effect without a clock edge; the first write is accepted on the first rising edge after deassertion.

Configuration
REQ-023 Macro REGFILE_BYPASS_EN: when defined, if ctrl_writeEn=1 and a read index equals ctrl_writeReg, that read port SHALL output data_writeReg combinationally (write-through), except during reset.
REQ-024 When REGFILE_BYPASS_EN is undefined, read ports SHALL output stored contents only (REQ-018).

Structure
REQ-025 Shared package regfile_pkg SHALL hold the default DATA_WIDTH/ADDR_WIDTH constants, a data-word typedef and an address typedef.
REQ-026 Sub-module regfile_reg SHALL implement one DATA_WIDTH register with async active-high clear and enable; regfile SHALL instantiate 2**ADDR_WIDTH copies and provide a one-hot write decoder plus two read multiplexers.

Verification
REQ-027 Assert ctrl_reset for 2 cycles, then read all 32 indices on A and B -> every read returns 32'h00000000.
REQ-028 For index 0..31: write 32'h0000DEAD, then set A=B=index -> both ports read 32'h0000DEAD, including index 0.
REQ-029 Write reg 5=32'h12345678 and reg 6=32'hCAFEF00D; A=5, B=6 -> A=32'h12345678, B=32'hCAFEF00D; swap indices -> outputs swap.
REQ-030 ctrl_writeEn=0 with ctrl_writeReg=7, data 32'hFFFFFFFF over 3 edges -> reg 7 keeps its previous value.
REQ-031 Write reg 9=32'hAAAA5555, then assert ctrl_reset between clock edges -> A=9 reads 0 before the next rising edge.
REQ-032 Write reg 3 with A=3 in the same cycle -> without REGFILE_BYPASS_EN, A shows the old value before the edge and the new value after; with it defined, A shows the new value before the edge.
